// File: rtl/div_fs_unmux_pkg.sv
// ----------------------------------------------------------------------------
// div_fs_unmux_pkg
// Shared constants for the 8-bit full-subtractor array divider.
//   DIV_W : operand width (dividend, divisor, quotient and remainder)
// ----------------------------------------------------------------------------
package div_fs_unmux_pkg;

    localparam int DIV_W = 8;

endpackage : div_fs_unmux_pkg

// File: rtl/div_fs_unmux_if.sv
// ----------------------------------------------------------------------------
// div_fs_unmux_if
// Operand/result bundle for the array divider.
//   SBC : dividend (unsigned)        SC : divisor (unsigned)
//   Q   : quotient, registered       R  : remainder, registered
// master drives operands and reads results; slave is the divider side.
// ----------------------------------------------------------------------------
interface div_fs_unmux_if;
    import div_fs_unmux_pkg::*;

    logic [DIV_W-1:0] SBC;
    logic [DIV_W-1:0] SC;
    logic [DIV_W-1:0] Q;
    logic [DIV_W-1:0] R;

    modport master (
        output SBC,
        output SC,
        input  Q,
        input  R
    );

    modport slave (
        input  SBC,
        input  SC,
        output Q,
        output R
    );

endinterface : div_fs_unmux_if

// File: rtl/div_fs_unmux_fs_cell.sv
// ----------------------------------------------------------------------------
// div_fs_unmux_fs_cell
// One full-subtractor cell of the restoring array with built-in restore gating.
//   x    : minuend bit            y    : subtrahend (divisor) bit
//   bin  : borrow in              q    : row quotient bit (1 = keep difference)
//   bout : borrow out             r    : q ? difference : minuend
// The restore is AND/OR gated rather than a mux so every cell is identical.
// ----------------------------------------------------------------------------
module div_fs_unmux_fs_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    input  logic q,
    output logic bout,
    output logic r
);

    logic d;

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
    assign r    = (d & q) | (x & ~q);

endmodule : div_fs_unmux_fs_cell

// File: rtl/div_fs_unmux.sv
// ----------------------------------------------------------------------------
// div_fs_unmux
// 8-bit unsigned restoring array divider built from full-subtractor cells,
// with a registered quotient/remainder (1-cycle latency, 1 result per cycle).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears Q and R
//   bus   : slave side of div_fs_unmux_if (SBC, SC in; Q, R out)
// SC = 0 is not special-cased: every row "succeeds", giving Q = 8'hFF, R = SBC.
// ----------------------------------------------------------------------------
module div_fs_unmux
    import div_fs_unmux_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    div_fs_unmux_if.slave   bus
);

    // Divisor widened by one bit so the shifted partial remainder (up to 9
    // bits) is compared without losing the final borrow.
    logic [DIV_W:0]   y_ext;
    logic [DIV_W-1:0] quot_w;
    logic [DIV_W-1:0] rem_w;

    logic [DIV_W-1:0] quot_d, quot_q;
    logic [DIV_W-1:0] rem_d,  rem_q;

    assign y_ext = {1'b0, bus.SC};

    // Row i (i = 7..0) subtracts the divisor from {previous remainder, SBC[i]}.
    // Every cell signal is its own scalar so the borrow and remainder ripple
    // never folds back into a single vector.
    genvar i, j;
    for (i = 0; i < DIV_W; i++) begin : g_row
        logic q_w;
        logic unused_msb;

        for (j = 0; j <= DIV_W; j++) begin : g_cell
            logic x_w;
            logic bin_w;
            logic bout_w;
            logic r_w;

            if (j == 0) begin : g_x_lsb
                assign x_w = bus.SBC[i];
            end else if (i == DIV_W - 1) begin : g_x_first
                assign x_w = 1'b0;
            end else begin : g_x_shift
                assign x_w = g_row[i+1].g_cell[j-1].r_w;
            end

            if (j == 0) begin : g_bin_lsb
                assign bin_w = 1'b0;
            end else begin : g_bin_chain
                assign bin_w = g_row[i].g_cell[j-1].bout_w;
            end

            div_fs_unmux_fs_cell u_fs (
                .x    (x_w),
                .y    (y_ext[j]),
                .bin  (bin_w),
                .q    (g_row[i].q_w),
                .bout (bout_w),
                .r    (r_w)
            );
        end

        // No borrow out of the top cell means the subtraction fits.
        assign q_w = ~g_cell[DIV_W].bout_w;

        // After a restore the row result is below SC, so its ninth bit is
        // always zero and is not carried to the next row.
        assign unused_msb = g_cell[DIV_W].r_w;

        assign quot_w[i] = q_w;
    end

    for (j = 0; j < DIV_W; j++) begin : g_rem
        assign rem_w[j] = g_row[0].g_cell[j].r_w;
    end

    always_comb begin
        quot_d = quot_w;
        rem_d  = rem_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot_q <= '0;
            rem_q  <= '0;
        end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
        end
    end

    assign bus.Q = quot_q;
    assign bus.R = rem_q;

endmodule : div_fs_unmux

// File: tb/tb_div_fs_unmux.sv
module tb_div_fs_unmux;
    import div_fs_unmux_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    div_fs_unmux_if bus_if ();

    div_fs_unmux dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] prev_q;
    logic [7:0] prev_r;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: integer division, with divide-by-zero giving all-ones / dividend.
    function automatic logic [7:0] ref_q(input int a, input int b);
        if (b == 0) return 8'hFF;
        return 8'(a / b);
    endfunction

    function automatic logic [7:0] ref_r(input int a, input int b);
        if (b == 0) return 8'(a);
        return 8'(a % b);
    endfunction

    // Called at a falling edge: apply operands, confirm outputs still hold the
    // previous result before the rising edge, then check one edge later.
    task automatic step(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input string tag);
        bus_if.SBC = a;
        bus_if.SC  = b;
        #1;
        chk({tag, "_hold_q"}, bus_if.Q, prev_q);
        chk({tag, "_hold_r"}, bus_if.R, prev_r);
        @(negedge clk);
        chk({tag, "_q"}, bus_if.Q, eq);
        chk({tag, "_r"}, bus_if.R, er);
        prev_q = eq;
        prev_r = er;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [7:0] sbc_t [9] = '{8'd243, 8'd100, 8'd255, 8'd255, 8'd50, 8'd231, 8'd77, 8'd0, 8'd255};
        logic [7:0] sc_t  [9] = '{8'd3,   8'd26,  8'd9,   8'd255, 8'd91, 8'd6,   8'd0,  8'd5, 8'd1};
        logic [7:0] q_t   [9] = '{8'd81,  8'd3,   8'd28,  8'd1,   8'd0,  8'd38,  8'd255, 8'd0, 8'd255};
        logic [7:0] r_t   [9] = '{8'd0,   8'd22,  8'd3,   8'd0,   8'd50, 8'd3,   8'd77, 8'd0, 8'd0};
        logic [7:0] a;
        logic [7:0] b;

        bus_if.SBC = 8'd243;
        bus_if.SC  = 8'd3;
        #2;
        chk("rst_q", bus_if.Q, 8'd0);
        chk("rst_r", bus_if.R, 8'd0);
        repeat (2) @(negedge clk);
        chk("rst_clk_q", bus_if.Q, 8'd0);
        chk("rst_clk_r", bus_if.R, 8'd0);

        // Release with 243/3 already present: first edge loads that result.
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_q", bus_if.Q, 8'd81);
        chk("release_r", bus_if.R, 8'd0);
        prev_q = 8'd81;
        prev_r = 8'd0;

        for (int k = 0; k < 9; k++)
            step(sbc_t[k], sc_t[k], q_t[k], r_t[k], $sformatf("dir%0d", k));

        for (int k = 0; k < 400; k++) begin
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            step(a, b, ref_q(int'(a), int'(b)), ref_r(int'(a), int'(b)), "rnd");
        end

        // Asynchronous reset in the middle of a cycle, then release mid-stream.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_q", bus_if.Q, 8'd0);
        chk("async_rst_r", bus_if.R, 8'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        prev_q = 8'd0;
        prev_r = 8'd0;
        step(8'd200, 8'd7, 8'd28, 8'd4, "after_rst");
        step(8'd7, 8'd200, 8'd0, 8'd7, "small");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_div_fs_unmux
